// File: rtl/cpu_kh_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_kh_pkg
// Purpose  : Shared opcode constants, instruction field positions, decode
//            helpers and ID-stage FSM state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_kh_pkg;

  // Opcodes
  localparam logic [3:0] c_op_nop    = 4'b0000;
  localparam logic [3:0] c_op_load   = 4'b0010;
  localparam logic [3:0] c_op_store  = 4'b0011;
  localparam logic [3:0] c_op_branch = 4'b0100;
  localparam logic [3:0] c_op_jump   = 4'b0101;

  // Instruction field positions (LSB of each field; imm is [15:0])
  localparam int c_op_lsb  = 28;
  localparam int c_rd_lsb  = 23;
  localparam int c_rs1_lsb = 18;
  localparam int c_rs2_lsb = 13;
  localparam int c_imm_msb = 15;

  // ID-stage FSM states
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } id_state_e;

  // Sign-extend the 16-bit immediate field
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // rs2 is a true data source for everything except loads and control flow,
  // whose rs2 bits overlap the immediate
  function automatic logic rs2_is_source(input logic [3:0] op);
    return !((op == c_op_load) || (op == c_op_branch) || (op == c_op_jump));
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_regfile.sv
//------------------------------------------------------------------------------
// Module   : cpu_regfile
// Purpose  : 2-read / 1-write register file, register 0 hardwired to zero.
//            Contents are not reset.
// Config   : CPU_ID_WB_BYPASS_EN - same-cycle write data forwarded to reads
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_regfile #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [31:0]       rs1_data_o,
  output logic [31:0]       rs2_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [31:0]       wdata_i
);

  logic [31:0] mem_q [2**REG_AW];

  // One read port: r0 reads zero, optional forwarding of the in-flight write
  function automatic logic [31:0] rd_port(
    input logic [REG_AW-1:0] addr,
    input logic [31:0]       stored,
    input logic              we,
    input logic [REG_AW-1:0] waddr,
    input logic [31:0]       wdata
  );
    logic [31:0] val;
    val = stored;
`ifdef CPU_ID_WB_BYPASS_EN
    if (we && (waddr == addr)) val = wdata;
`else
    if (we && (waddr == addr) && 1'b0) val = wdata;
`endif
    if (addr == '0) val = '0;
    return val;
  endfunction

  // Write port; writes to register 0 are dropped
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rs1_data_o = rd_port(rs1_addr_i, mem_q[rs1_addr_i], we_i, waddr_i, wdata_i);
  assign rs2_data_o = rd_port(rs2_addr_i, mem_q[rs2_addr_i], we_i, waddr_i, wdata_i);

endmodule

`default_nettype wire

// File: rtl/cpu_id.sv
//------------------------------------------------------------------------------
// Module   : cpu_id
// Purpose  : Instruction decode stage. Registers decoded fields and operand
//            values, detects load-use hazards and inserts a single bubble.
// Config   : CPU_ID_WB_BYPASS_EN - write-back to read-port forwarding
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_id
  import cpu_kh_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [31:0]       PC_IF,
  input  logic [31:0]       IR,
  input  logic              WB_we,
  input  logic [REG_AW-1:0] WB_addr,
  input  logic [31:0]       WB_data,
  output logic [31:0]       PC_ID,
  output logic [3:0]        OP_ID,
  output logic [REG_AW-1:0] RD_ID,
  output logic [31:0]       RS1_val,
  output logic [31:0]       RS2_val,
  output logic [31:0]       IMM_ID,
  output logic              IS_LOAD_ID,
  output logic              LOAD_happened
);

  // Decoded fields of the incoming instruction
  logic [3:0]        op_w;
  logic [REG_AW-1:0] rd_w;
  logic [REG_AW-1:0] rs1_w;
  logic [REG_AW-1:0] rs2_w;
  logic [31:0]       imm_w;
  logic [31:0]       rs1_data_w;
  logic [31:0]       rs2_data_w;

  assign op_w  = IR[c_op_lsb +: 4];
  assign rd_w  = IR[c_rd_lsb +: REG_AW];
  assign rs1_w = IR[c_rs1_lsb +: REG_AW];
  assign rs2_w = IR[c_rs2_lsb +: REG_AW];
  assign imm_w = sext16(IR[c_imm_msb:0]);

  cpu_regfile #(
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk        (clk),
    .rs1_addr_i (rs1_w),
    .rs2_addr_i (rs2_w),
    .rs1_data_o (rs1_data_w),
    .rs2_data_o (rs2_data_w),
    .we_i       (WB_we),
    .waddr_i    (WB_addr),
    .wdata_i    (WB_data)
  );

  // Pipeline registers
  id_state_e         state_q, state_d;
  logic [31:0]       pc_q;
  logic [3:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [31:0]       rs1v_q;
  logic [31:0]       rs2v_q;
  logic [31:0]       imm_q;
  logic              isload_q;

  logic hazard_w;
  logic capture_d;
  logic bubble_d;
  logic load_happened_d;

  // Load in ID whose destination feeds the instruction now in IR
  always_comb begin
    hazard_w = isload_q && (rd_q != '0) &&
               ((rd_q == rs1_w) || ((rd_q == rs2_w) && rs2_is_source(op_w)));
  end

  // Next-state and datapath control; en=0 freezes everything
  always_comb begin
    state_d         = state_q;
    capture_d       = 1'b0;
    bubble_d        = 1'b0;
    load_happened_d = 1'b0;
    if (en) begin
      case (state_q)
        ST_RUN: begin
          if (hazard_w) begin
            state_d         = ST_STALL;
            bubble_d        = 1'b1;
            load_happened_d = 1'b1;
          end else begin
            capture_d = 1'b1;
          end
        end
        ST_STALL: begin
          state_d   = ST_RUN;
          capture_d = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Decoded-field registers: capture, bubble (PC held) or hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rs1v_q   <= '0;
      rs2v_q   <= '0;
      imm_q    <= '0;
      isload_q <= 1'b0;
    end else if (bubble_d) begin
      op_q     <= c_op_nop;
      rd_q     <= '0;
      rs1v_q   <= '0;
      rs2v_q   <= '0;
      imm_q    <= '0;
      isload_q <= 1'b0;
    end else if (capture_d) begin
      pc_q     <= PC_IF;
      op_q     <= op_w;
      rd_q     <= rd_w;
      rs1v_q   <= rs1_data_w;
      rs2v_q   <= rs2_data_w;
      imm_q    <= imm_w;
      isload_q <= (op_w == c_op_load);
    end
  end

  assign PC_ID         = pc_q;
  assign OP_ID         = op_q;
  assign RD_ID         = rd_q;
  assign RS1_val       = rs1v_q;
  assign RS2_val       = rs2v_q;
  assign IMM_ID        = imm_q;
  assign IS_LOAD_ID    = isload_q;
  assign LOAD_happened = load_happened_d;

endmodule

`default_nettype wire

// File: tb/tb_cpu_id.sv
//------------------------------------------------------------------------------
// Module   : tb_cpu_id
// Purpose  : Self-checking bench for cpu_id against a behavioural model.
// Config   : CPU_ID_WB_BYPASS_EN - selects the forwarding behaviour expected
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_id;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] PC_IF = '0;
  logic [31:0] IR = '0;
  logic        WB_we = 1'b0;
  logic [4:0]  WB_addr = '0;
  logic [31:0] WB_data = '0;
  logic [31:0] PC_ID;
  logic [3:0]  OP_ID;
  logic [4:0]  RD_ID;
  logic [31:0] RS1_val;
  logic [31:0] RS2_val;
  logic [31:0] IMM_ID;
  logic        IS_LOAD_ID;
  logic        LOAD_happened;

  cpu_id #(.REG_AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .PC_IF         (PC_IF),
    .IR            (IR),
    .WB_we         (WB_we),
    .WB_addr       (WB_addr),
    .WB_data       (WB_data),
    .PC_ID         (PC_ID),
    .OP_ID         (OP_ID),
    .RD_ID         (RD_ID),
    .RS1_val       (RS1_val),
    .RS2_val       (RS2_val),
    .IMM_ID        (IMM_ID),
    .IS_LOAD_ID    (IS_LOAD_ID),
    .LOAD_happened (LOAD_happened)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers plus the expected stage outputs
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_ld;

  int n_chk  = 0;
  int n_pass = 0;
  int n_haz  = 0;
  logic last_haz = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int lo);
    return {op[3:0], rd[4:0], rs1[4:0], rs2[4:0], lo[12:0]};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef CPU_ID_WB_BYPASS_EN
    if (WB_we && WB_addr == a) return WB_data;
`endif
    return m_regs[a];
  endfunction

  // A load in ID stalls a consumer; the bubble clears m_ld so it never repeats
  function automatic logic m_hazard();
    logic [3:0] op;
    op = IR[31:28];
    if (!en || !m_ld || m_rd == 5'd0) return 1'b0;
    if (m_rd == IR[22:18]) return 1'b1;
    return (m_rd == IR[17:13]) && !(op == 4'h2 || op == 4'h4 || op == 4'h5);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".PC_ID"},   PC_ID,              m_pc);
    check({tag, ".OP_ID"},   {28'd0, OP_ID},     {28'd0, m_op});
    check({tag, ".RD_ID"},   {27'd0, RD_ID},     {27'd0, m_rd});
    check({tag, ".RS1_val"}, RS1_val,            m_a);
    check({tag, ".RS2_val"}, RS2_val,            m_b);
    check({tag, ".IMM_ID"},  IMM_ID,             m_imm);
    check({tag, ".IS_LOAD"}, {31'd0, IS_LOAD_ID}, {31'd0, m_ld});
  endtask

  // One clock: check the stall request mid-cycle, then the registered outputs
  task automatic cycle(input string tag);
    logic        h, wr;
    logic [4:0]  wa;
    logic [31:0] wd, n_pc, n_a, n_b, n_imm;
    logic [3:0]  n_op;
    logic [4:0]  n_rd;
    logic        n_ld;
    @(negedge clk);
    h = rst ? m_hazard() : 1'b0;
    check({tag, ".LOAD_happened"}, {31'd0, LOAD_happened}, {31'd0, h});
    if (h) n_haz++;
    last_haz = h;
    n_pc = m_pc; n_op = m_op; n_rd = m_rd; n_a = m_a; n_b = m_b; n_imm = m_imm; n_ld = m_ld;
    if (rst && en) begin
      if (h) begin
        n_op = 4'd0; n_rd = 5'd0; n_a = 32'd0; n_b = 32'd0; n_imm = 32'd0; n_ld = 1'b0;
      end else begin
        n_pc  = PC_IF;
        n_op  = IR[31:28];
        n_rd  = IR[27:23];
        n_a   = m_read(IR[22:18]);
        n_b   = m_read(IR[17:13]);
        n_imm = {{16{IR[15]}}, IR[15:0]};
        n_ld  = (IR[31:28] == 4'h2);
      end
    end
    wr = WB_we && (WB_addr != 5'd0);
    wa = WB_addr;
    wd = WB_data;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_op = n_op; m_rd = n_rd; m_a = n_a; m_b = n_b; m_imm = n_imm; m_ld = n_ld;
    if (wr) m_regs[wa] = wd;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check({tag, ".PC_ID"},   PC_ID,                0);
    check({tag, ".OP_ID"},   {28'd0, OP_ID},       0);
    check({tag, ".RD_ID"},   {27'd0, RD_ID},       0);
    check({tag, ".RS1_val"}, RS1_val,              0);
    check({tag, ".RS2_val"}, RS2_val,              0);
    check({tag, ".IMM_ID"},  IMM_ID,               0);
    check({tag, ".IS_LOAD"}, {31'd0, IS_LOAD_ID},  0);
    check({tag, ".LOAD_happened"}, {31'd0, LOAD_happened}, 0);
    m_pc = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_ld = 0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_ir();
    int sel;
    int ops [8] = '{0, 1, 2, 2, 3, 4, 5, 9};
    sel = $urandom_range(0, 19);
    if (sel == 0) return 32'h0;
    if (sel == 1) return 32'h4000_0000;
    return mk(ops[$urandom_range(0, 7)], $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom);
  endfunction

  initial begin
    int haz0;
    logic [31:0] exp_byp;
    m_pc = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_ld = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

    // Fill the register file while held in reset (writes are not reset)
    #1;
    compare_all("reset");
    for (int i = 1; i < 32; i++) begin
      WB_we = 1'b1;
      WB_addr = i[4:0];
      WB_data = (i == 2) ? 32'd7 : (i == 4) ? 32'd9 : (i == 5) ? 32'hA5A5_0001 : $urandom;
      IR = rand_ir();
      cycle("init");
    end
    WB_we = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Decode: rs1 field = 2 (holds 7), rs2 field = 4 (holds 9), imm 0x8004
    en = 1'b1; PC_IF = 32'h100; IR = 32'h1088_8004;
    cycle("decode");
    check("decode.op",  {28'd0, OP_ID}, 32'd1);
    check("decode.rd",  {27'd0, RD_ID}, 32'd1);
    check("decode.rs1", RS1_val, 32'd7);
    check("decode.rs2", RS2_val, 32'd9);
    check("decode.imm", IMM_ID, 32'hFFFF_8004);

    // Load-use on rs1: one stall request, one bubble, then the consumer
    haz0 = n_haz;
    PC_IF = 32'h104; IR = mk(2, 3, 1, 0, 0);
    cycle("lu.load");
    PC_IF = 32'h108; IR = mk(1, 6, 3, 1, 0);
    cycle("lu.use");
    check("lu.bubble_op", {28'd0, OP_ID}, 32'd0);
    check("lu.bubble_pc", PC_ID, 32'h104);
    cycle("lu.replay");
    check("lu.replay_op", {28'd0, OP_ID}, 32'd1);
    check("lu.stall_count", n_haz - haz0, 32'd1);

    // r0: a load to r0 never stalls, and r0 ignores writes
    haz0 = n_haz;
    PC_IF = 32'h10C; IR = mk(2, 0, 0, 0, 0);
    cycle("r0.load");
    PC_IF = 32'h110; IR = mk(1, 7, 0, 0, 0);
    WB_we = 1'b1; WB_addr = 5'd0; WB_data = 32'hFFFF_FFFF;
    cycle("r0.use");
    WB_we = 1'b0;
    PC_IF = 32'h114; IR = mk(1, 7, 0, 0, 0);
    cycle("r0.read");
    check("r0.rs1", RS1_val, 32'd0);
    check("r0.no_stall", n_haz - haz0, 32'd0);

    // Same-cycle write-back to the register being read
`ifdef CPU_ID_WB_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'd9;
`endif
    PC_IF = 32'h118; IR = mk(1, 8, 4, 0, 0);
    WB_we = 1'b1; WB_addr = 5'd4; WB_data = 32'h1234;
    cycle("bypass");
    check("bypass.rs1", RS1_val, exp_byp);
    WB_we = 1'b0;

    // Hold: en=0 for three cycles with a changing IR
    for (int i = 0; i < 3; i++) begin
      en = 1'b0; PC_IF = 32'h200 + i * 4; IR = mk(2, 3, 3, 3, i);
      cycle("hold");
    end
    check("hold.pc", PC_ID, 32'h118);
    en = 1'b1;

    // Reset taken while stalled; register contents survive
    PC_IF = 32'h120; IR = mk(2, 3, 0, 0, 0);
    cycle("rs.load");
    PC_IF = 32'h124; IR = mk(1, 6, 3, 0, 0);
    cycle("rs.use");
    pulse_reset("rs");
    PC_IF = 32'h128; IR = mk(1, 9, 5, 0, 0);
    cycle("rs.after");
    check("rs.r5", RS1_val, 32'hA5A5_0001);

    // Randomized traffic; fetch holds IR/PC while a stall is requested
    for (int i = 0; i < 400; i++) begin
      if (!last_haz) begin
        PC_IF = PC_IF + 4;
        IR = rand_ir();
      end
      en = ($urandom_range(0, 9) != 0);
      WB_we = $urandom_range(0, 1) == 1;
      WB_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      WB_data = $urandom;
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
